// File: rtl/mult_8x8_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mult_8x8_seq_ctrl
//  Purpose  : Computes one 8x8 product by running a single external 4x4
//             sub-multiplier over four quadrant passes. The shifted partials
//             are accumulated into a 16-bit result. Operands arrive and
//             results leave over valid/ready handshakes.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SKIP_ZERO  : 1 = a pair with A==0 or B==0 bypasses the quadrant passes
//  Build macro
//    MULT_SEQ_OR_ACC_EN : when defined, partials are OR-combined
//                         (approximate); otherwise they are added (exact).
//  Ports
//    clk, rst_n           : clock, asynchronous active-low reset
//    in_valid/in_ready    : operand handshake, A/B sampled on accept
//    out_valid/out_ready  : result handshake, R registered and held
//    mul_a/mul_b/mul_q    : nibble operands and quadrant index to sub-mult
//    mul_p                : sub-multiplier product (same cycle)
//    busy                 : high while quadrant passes are running
// ============================================================================
module mult_8x8_seq_ctrl #(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] R,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    output logic [1:0]  mul_q,
    input  logic [7:0]  mul_p,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_cnt;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic [15:0] r_r;
    logic        r_out_valid;
    logic        r_busy;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_skip;
    logic [3:0]  w_shift;
    logic [15:0] w_part;
    logic [15:0] w_acc_next;

    // ------------------------------------------------------------------
    // Handshake and next-state logic. In DONE, readiness follows out_ready
    // so a new pair can be taken on the same edge the result is consumed.
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready   = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
        w_accept     = in_valid && w_in_ready;
        w_skip       = SKIP_ZERO && ((A == 8'd0) || (B == 8'd0));
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_skip ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_cnt == 2'd3) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (w_accept) begin
                        w_state_next = w_skip ? ST_DONE : ST_CALC;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Quadrant steering: drives the sub-multiplier only while calculating.
    // ------------------------------------------------------------------
    always_comb begin
        mul_a   = 4'd0;
        mul_b   = 4'd0;
        mul_q   = 2'd0;
        w_shift = 4'd0;
        if (r_state == ST_CALC) begin
            mul_q = r_cnt;
            case (r_cnt)
                2'd0: begin mul_a = r_a[3:0]; mul_b = r_b[3:0]; w_shift = 4'd0; end
                2'd1: begin mul_a = r_a[3:0]; mul_b = r_b[7:4]; w_shift = 4'd4; end
                2'd2: begin mul_a = r_a[7:4]; mul_b = r_b[3:0]; w_shift = 4'd4; end
                default: begin mul_a = r_a[7:4]; mul_b = r_b[7:4]; w_shift = 4'd8; end
            endcase
        end
    end

    assign w_part = {8'd0, mul_p} << w_shift;

`ifdef MULT_SEQ_OR_ACC_EN
    assign w_acc_next = r_acc | w_part;
`else
    assign w_acc_next = r_acc + w_part;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 2'd0;
            r_a         <= 8'd0;
            r_b         <= 8'd0;
            r_acc       <= 16'd0;
            r_r         <= 16'd0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= (w_state_next == ST_DONE);
            r_busy      <= (w_state_next == ST_CALC);
            if (w_accept) begin
                r_a   <= A;
                r_b   <= B;
                r_acc <= 16'd0;
                r_cnt <= 2'd0;
                if (w_skip) begin
                    r_r <= 16'd0;
                end
            end else if (r_state == ST_CALC) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 2'd1;
                // Last pass: publish the result including this pass's partial.
                if (r_cnt == 2'd3) begin
                    r_r <= w_acc_next;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign R         = r_r;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mult_8x8_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_8x8_seq_ctrl
//  Purpose  : Self-checking bench for mult_8x8_seq_ctrl with an exact 4x4
//             sub-multiplier model. Main instance uses SKIP_ZERO=0, a second
//             instance uses SKIP_ZERO=1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_8x8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  A = 8'd0;
    logic [7:0]  B = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] R;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [1:0]  mul_q;
    logic [7:0]  mul_p;
    logic        busy;

    logic        z_in_valid = 1'b0;
    logic        z_in_ready;
    logic [7:0]  z_A = 8'd0;
    logic [7:0]  z_B = 8'd0;
    logic        z_out_valid;
    logic        z_out_ready = 1'b0;
    logic [15:0] z_R;
    logic [3:0]  z_mul_a;
    logic [3:0]  z_mul_b;
    logic [1:0]  z_mul_q;
    logic [7:0]  z_mul_p;
    logic        z_busy;
    logic        z_busy_seen = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mul_p   = {4'd0, mul_a} * {4'd0, mul_b};
    assign z_mul_p = {4'd0, z_mul_a} * {4'd0, z_mul_b};

    mult_8x8_seq_ctrl #(.SKIP_ZERO(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .R(R),
        .mul_a(mul_a), .mul_b(mul_b), .mul_q(mul_q), .mul_p(mul_p), .busy(busy)
    );

    mult_8x8_seq_ctrl #(.SKIP_ZERO(1'b1)) u_dut_skip (
        .clk(clk), .rst_n(rst_n), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .A(z_A), .B(z_B), .out_valid(z_out_valid), .out_ready(z_out_ready), .R(z_R),
        .mul_a(z_mul_a), .mul_b(z_mul_b), .mul_q(z_mul_q), .mul_p(z_mul_p), .busy(z_busy)
    );

    always @(posedge clk) begin
        if (z_busy) z_busy_seen <= 1'b1;
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] r_add;
        logic [15:0] r_or;
    } vec_t;

    vec_t vecs [10];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_SEQ_OR_ACC_EN
        logic [15:0] p0, p1, p2, p3;
        p0 = 16'(a[3:0]) * 16'(b[3:0]);
        p1 = (16'(a[3:0]) * 16'(b[7:4])) << 4;
        p2 = (16'(a[7:4]) * 16'(b[3:0])) << 4;
        p3 = (16'(a[7:4]) * 16'(b[7:4])) << 8;
        return p0 | p1 | p2 | p3;
`else
        return 16'(a) * 16'(b);
`endif
    endfunction

    function automatic logic [15:0] pick(input vec_t v);
`ifdef MULT_SEQ_OR_ACC_EN
        return v.r_or;
`else
        return v.r_add;
`endif
    endfunction

    // One complete operation on the main instance, checking latency,
    // quadrant sequence, nibble steering, busy and the final result.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        int lat;
        logic qok;
        logic [3:0] ea, eb;
        lat = 0;
        qok = 1'b1;
        A = a;
        B = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        while (!out_valid && lat < 10) begin
            if (lat < 4) begin
                ea = (lat < 2) ? a[3:0] : a[7:4];
                eb = (lat[0] == 1'b0) ? b[3:0] : b[7:4];
                if (mul_q !== 2'(lat) || mul_a !== ea || mul_b !== eb || busy !== 1'b1)
                    qok = 1'b0;
            end
            tick();
            lat++;
        end
        chk("latency", lat, 4);
        chk("quadrant_seq", {31'd0, qok}, 32'd1);
        chk("result", {16'd0, R}, {16'd0, exp});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("consume_clears_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic z_op(input logic [7:0] a, input logic [7:0] b, input int exp_lat,
                        input logic [15:0] exp);
        int lat;
        lat = 0;
        z_A = a;
        z_B = b;
        z_in_valid = 1'b1;
        tick();
        z_in_valid = 1'b0;
        while (!z_out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("skip_latency", lat, exp_lat);
        chk("skip_result", {16'd0, z_R}, {16'd0, exp});
        z_out_ready = 1'b1;
        tick();
        z_out_ready = 1'b0;
    endtask

    localparam int N_RND = 1000;

    initial begin
        logic [15:0] sbq [$];
        int sent, recv, cyc, lat;
        logic acc_h, cons_h;

        vecs[0] = '{8'hFF, 8'hFF, 16'hFE01, 16'hEFF1};
        vecs[1] = '{8'h13, 8'h11, 16'h0143, 16'h0133};
        vecs[2] = '{8'h0A, 8'h0C, 16'h0078, 16'h0078};
        vecs[3] = '{8'h02, 8'h03, 16'h0006, 16'h0006};
        vecs[4] = '{8'h12, 8'h34, 16'h03A8, 16'h0368};
        vecs[5] = '{8'h80, 8'h02, 16'h0100, 16'h0100};
        vecs[6] = '{8'hF0, 8'h0F, 16'h0E10, 16'h0E10};
        vecs[7] = '{8'h00, 8'h5A, 16'h0000, 16'h0000};
        vecs[8] = '{8'h7F, 8'h81, 16'h3FFF, 16'h3FFF};
        vecs[9] = '{8'h01, 8'h01, 16'h0001, 16'h0001};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_R", {16'd0, R}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mul", {22'd0, mul_a, mul_b, mul_q}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, pick(vecs[i]));
        end

        // Backpressure: result held, other pairs ignored until consume edge
        A = 8'h0A;
        B = 8'h0C;
        in_valid = 1'b1;
        tick();
        A = 8'h33;
        B = 8'h33;
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("bp_latency", lat, 4);
        for (int i = 0; i < 6; i++) begin
            chk("bp_R_stable", {16'd0, R}, 32'h0078);
            chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            tick();
        end
        A = 8'h55;
        B = 8'h02;
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_follows", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("bp_overlap_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_overlap_busy", {31'd0, busy}, 32'd1);
        chk("bp_overlap_nibbles", {24'd0, mul_a, mul_b}, 32'h52);
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("bp_second_R", {16'd0, R}, 32'h00AA);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Bypass of zero operands on the SKIP_ZERO instance
        z_op(8'h00, 8'h5A, 0, 16'h0000);
        z_op(8'h5A, 8'h00, 0, 16'h0000);
        chk("skip_busy_never", {31'd0, z_busy_seen}, 32'd0);
        z_op(8'h03, 8'h05, 4, 16'h000F);

        // Asynchronous reset in the middle of the passes
        A = 8'hFF;
        B = 8'hFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("abort_at_cnt2", {30'd0, mul_q}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_R", {16'd0, R}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_mul", {22'd0, mul_a, mul_b, mul_q}, 32'd0);
        #1;
        rst_n = 1'b1;
        run_op(8'h02, 8'h03, 16'h0006);

        // Random stream with gaps on both sides, checked in order
        sent = 0;
        recv = 0;
        cyc = 0;
        in_valid = 1'b0;
        while (recv < N_RND && cyc < 60000) begin
            if (!in_valid && sent < N_RND && ($urandom % 4) != 0) begin
                A = 8'($urandom);
                B = 8'($urandom);
                in_valid = 1'b1;
            end
            out_ready = (($urandom % 3) != 0);
            #3;
            acc_h = in_valid && in_ready;
            cons_h = out_valid && out_ready;
            if (cons_h) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rnd_extra_result actual=0x%0h expected=none", R);
                end else begin
                    chk("rnd_R", {16'd0, R}, {16'd0, sbq.pop_front()});
                end
                recv++;
            end
            if (acc_h) begin
                sbq.push_back(model(A, B));
                sent++;
            end
            tick();
            cyc++;
            if (acc_h) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("rnd_count", recv, N_RND);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
